hf_subcarrier_rx: RTL and testbench

Parametrised ISO14443 reader-side receive/transport block that generalises the fixed fc/16, 8-bit-frame tag-response detector.
- Filters ADC samples with a Gaussian-derivative kernel.
- Detects subcarrier modulation per bit period against a runtime threshold.
- Packs decisions into words.
- Generates the SSP clock, frame and data to the ARM.
- Registers the ARM modulation bit for the coil driver.
Sits between adc_d/ssp_dout and the pwr_hi/ssp pins inside fpga_hf.

---
 rtl/hf_pkg.sv | 24 ++
 rtl/hf_edge_filter.sv | 55 +++++
 rtl/hf_subcarrier_rx.sv | 161 ++++++++++++++++
 tb/tb_hf_subcarrier_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hf_pkg.sv
// hf_pkg: shared constants for the HF front-end blocks inside fpga_hf.
//   - major mode codes as decoded from conf_word
//   - power-on defaults for the edge-detect threshold and detector reset phase
//   - receive FSM state encodings
package hf_pkg;

    // Major modes selected by conf_word.
    typedef enum logic [2:0] {
        SNIFFER       = 3'd0,
        TAGSIM_LISTEN = 3'd1,
        TAGSIM_MOD    = 3'd2,
        READER_LISTEN = 3'd3,
        READER_MOD    = 3'd4
    } hf_mode_e;

    // Default runtime settings driven by the ARM after power-up.
    localparam int unsigned EDGE_DETECT_THRESHOLD_DEF = 40;
    localparam int unsigned MOD_DETECT_RESET_DEF      = 3;

    // Receive FSM states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/hf_edge_filter.sv
// hf_edge_filter: Gaussian-derivative edge filter over the ADC sample stream.
//
// Ports:
//   osc_clk    in   carrier clock, state updates on the falling edge
//   rst        in   synchronous active-high reset
//   adc_d      in   unsigned ADC sample (ADC_W bits)
//   y          out  signed filter output (FILT_W bits), combinational from adc_d and history
//   hist_full  out  high once four samples have entered the history since reset
module hf_edge_filter #(
    parameter int unsigned ADC_W  = 8,
    parameter int unsigned FILT_W = ADC_W + 3
) (
    input  logic                     osc_clk,
    input  logic                     rst,
    input  logic [ADC_W-1:0]         adc_d,
    output logic signed [FILT_W-1:0] y,
    output logic                     hist_full
);

    localparam int unsigned TERM_W = ADC_W + 2;

    logic [ADC_W-1:0]  x1, x2, x3, x4;
    logic [2:0]        hist_cnt;
    logic [TERM_W-1:0] pos_term;
    logic [TERM_W-1:0] neg_term;

    // History shifts on every tick regardless of the receive state.
    always_ff @(negedge osc_clk) begin
        if (rst) begin
            x1       <= '0;
            x2       <= '0;
            x3       <= '0;
            x4       <= '0;
            hist_cnt <= '0;
        end else begin
            x1 <= adc_d;
            x2 <= x1;
            x3 <= x2;
            x4 <= x3;
            if (hist_cnt != 3'd4) begin
                hist_cnt <= hist_cnt + 3'd1;
            end
        end
    end

    // y = (2*x4 + x3) - (2*adc_d + x1); each term fits in ADC_W+2 bits unsigned,
    // so the difference always fits a signed FILT_W without saturation.
    always_comb begin
        pos_term  = {1'b0, x4, 1'b0} + {2'b00, x3};
        neg_term  = {1'b0, adc_d, 1'b0} + {2'b00, x1};
        y         = signed'(FILT_W'(pos_term)) - signed'(FILT_W'(neg_term));
        hist_full = (hist_cnt == 3'd4);
    end

endmodule

// File: rtl/hf_subcarrier_rx.sv
// hf_subcarrier_rx: reader-side ISO14443 subcarrier receiver and SSP transport.
// Filters ADC samples, decides per bit period whether subcarrier modulation was present,
// packs decisions into words and serialises the latest decision to the ARM over SSP.
// Also registers the ARM modulation bit for the coil driver.
//
// Ports:
//   osc_clk       in   carrier clock, all state changes on its falling edge
//   rst           in   synchronous active-high reset (priority over enable)
//   enable        in   run request (READER_LISTEN decode)
//   adc_d         in   unsigned ADC sample
//   threshold     in   unsigned edge threshold, sampled live
//   reset_phase   in   bit-period phase at which the detector decides and clears
//   tx_bit        in   ssp_dout from the ARM
//   mod_sig_coil  out  tx_bit delayed by one tick
//   curbit        out  latest modulation decision
//   frame_word    out  last completed decision word, MSB = first decision
//   frame_valid   out  one-tick pulse when frame_word updates
//   ssp_clk       out  SSP clock, one bit period per cycle
//   ssp_frame     out  SSP frame marker
//   ssp_din       out  SSP data (latest decision, held for one bit period)
module hf_subcarrier_rx
    import hf_pkg::*;
#(
    parameter int unsigned ADC_W       = 8,
    parameter int unsigned PERIOD_LOG2 = 4,
    parameter int unsigned FRAME_BITS  = 8,
    parameter int unsigned FILT_W      = ADC_W + 3
) (
    input  logic                   osc_clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [ADC_W-1:0]       adc_d,
    input  logic [FILT_W-2:0]      threshold,
    input  logic [PERIOD_LOG2-1:0] reset_phase,
    input  logic                   tx_bit,
    output logic                   mod_sig_coil,
    output logic                   curbit,
    output logic [FRAME_BITS-1:0]  frame_word,
    output logic                   frame_valid,
    output logic                   ssp_clk,
    output logic                   ssp_frame,
    output logic                   ssp_din
);

    localparam int unsigned FRAME_LOG2 = $clog2(FRAME_BITS);
    localparam int unsigned CNT_W      = PERIOD_LOG2 + FRAME_LOG2;
    localparam int unsigned HALF       = 2 ** (PERIOD_LOG2 - 1);

    localparam logic [PERIOD_LOG2-1:0] PH_ZERO  = '0;
    localparam logic [PERIOD_LOG2-1:0] PH_HALF  = PERIOD_LOG2'(HALF);
    localparam logic [CNT_W-1:0]       FR_SET   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]       FR_CLR   = CNT_W'((2 ** PERIOD_LOG2) + HALF - 1);
    localparam logic [FRAME_LOG2-1:0]  LAST_BIT = FRAME_LOG2'(FRAME_BITS - 1);
    localparam logic signed [FILT_W-1:0] ZERO   = '0;

    logic                     state;
    logic [CNT_W-1:0]         tick_cnt;
    logic [PERIOD_LOG2-1:0]   phase;
    logic [FRAME_LOG2-1:0]    bit_idx;
    logic signed [FILT_W-1:0] y;
    logic                     hist_full;
    logic signed [FILT_W-1:0] max_val;
    logic signed [FILT_W-1:0] min_val;
    logic signed [FILT_W-1:0] thr_pos;
    logic signed [FILT_W-1:0] thr_neg;
    logic                     decide;
    logic                     decision;
    logic [FRAME_BITS-1:0]    shreg;
    logic [FRAME_BITS-1:0]    next_word;

    hf_edge_filter #(
        .ADC_W  (ADC_W),
        .FILT_W (FILT_W)
    ) u_edge_filter (
        .osc_clk   (osc_clk),
        .rst       (rst),
        .adc_d     (adc_d),
        .y         (y),
        .hist_full (hist_full)
    );

    always_comb begin
        phase     = tick_cnt[PERIOD_LOG2-1:0];
        bit_idx   = tick_cnt[CNT_W-1:PERIOD_LOG2];
        thr_pos   = signed'({1'b0, threshold});
        thr_neg   = -thr_pos;
        decide    = (phase == reset_phase);
        // Modulation needs both a rising and a falling edge inside the period.
        decision  = (max_val > thr_pos) && (min_val < thr_neg);
        next_word = {shreg[FRAME_BITS-2:0], decision};
    end

    always_ff @(negedge osc_clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            max_val      <= '0;
            min_val      <= '0;
            shreg        <= '0;
            mod_sig_coil <= 1'b0;
            curbit       <= 1'b0;
            frame_word   <= '0;
            frame_valid  <= 1'b0;
            ssp_clk      <= 1'b0;
            ssp_frame    <= 1'b0;
            ssp_din      <= 1'b0;
        end else begin
            mod_sig_coil <= tx_bit;
            frame_valid  <= 1'b0;

            if (state == ST_IDLE || !enable) begin
                // Idle, or leaving RUN: any partial frame is dropped and SSP goes quiet
                // on this same edge. Only IDLE with enable=1 moves on to RUN.
                state     <= (state == ST_IDLE && enable) ? ST_RUN : ST_IDLE;
                tick_cnt  <= '0;
                max_val   <= '0;
                min_val   <= '0;
                shreg     <= '0;
                curbit    <= 1'b0;
                ssp_clk   <= 1'b0;
                ssp_frame <= 1'b0;
                ssp_din   <= 1'b0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;

                if (phase == PH_ZERO) begin
                    ssp_clk <= 1'b1;
                    ssp_din <= curbit;
                end else if (phase == PH_HALF) begin
                    ssp_clk <= 1'b0;
                end

                if (tick_cnt == FR_SET) begin
                    ssp_frame <= 1'b1;
                end else if (tick_cnt == FR_CLR) begin
                    ssp_frame <= 1'b0;
                end

                if (decide) begin
                    // The sample arriving on the decide tick is deliberately not tracked.
                    curbit  <= decision;
                    max_val <= '0;
                    min_val <= '0;
                    shreg   <= next_word;
                    if (bit_idx == LAST_BIT) begin
                        frame_word  <= next_word;
                        frame_valid <= 1'b1;
                    end
                end else if (hist_full) begin
                    if (y > ZERO && y > max_val) begin
                        max_val <= y;
                    end
                    if (y <= ZERO && y < min_val) begin
                        min_val <= y;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hf_subcarrier_rx.sv
module tb_hf_subcarrier_rx;

    logic       osc_clk = 1'b1;
    logic       rst;
    logic       enable;
    logic       tx_bit;
    logic [7:0] adc_d;
    logic [9:0] threshold;
    logic [3:0] rp_a;
    logic [4:0] rp_b;

    // DUT a: defaults (fc/16, 8-bit frames). DUT b: fc/32, 4-bit frames.
    logic       a_mod, a_cb, a_fv, a_clk, a_frm, a_din;
    logic [7:0] a_fw;
    logic       b_mod, b_cb, b_fv, b_clk, b_frm, b_din;
    logic [3:0] b_fw;

    int         n_chk = 0;
    int         n_fail = 0;
    int         sq_cnt = 0;
    int         adc_mode = 0;  // 0 random, 1 square wave, 2 constant 128
    logic [7:0] amp = 8'd0;
    logic       tx_prev = 1'b0;

    always #5 osc_clk = ~osc_clk;

    hf_subcarrier_rx u_dut_a (
        .osc_clk      (osc_clk),
        .rst          (rst),
        .enable       (enable),
        .adc_d        (adc_d),
        .threshold    (threshold),
        .reset_phase  (rp_a),
        .tx_bit       (tx_bit),
        .mod_sig_coil (a_mod),
        .curbit       (a_cb),
        .frame_word   (a_fw),
        .frame_valid  (a_fv),
        .ssp_clk      (a_clk),
        .ssp_frame    (a_frm),
        .ssp_din      (a_din)
    );

    hf_subcarrier_rx #(
        .PERIOD_LOG2 (5),
        .FRAME_BITS  (4)
    ) u_dut_b (
        .osc_clk      (osc_clk),
        .rst          (rst),
        .enable       (enable),
        .adc_d        (adc_d),
        .threshold    (threshold),
        .reset_phase  (rp_b),
        .tx_bit       (tx_bit),
        .mod_sig_coil (b_mod),
        .curbit       (b_cb),
        .frame_word   (b_fw),
        .frame_valid  (b_fv),
        .ssp_clk      (b_clk),
        .ssp_frame    (b_frm),
        .ssp_din      (b_din)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One carrier tick: drive inputs, let the falling edge happen, sample 1 time unit later.
    task automatic step();
        tx_prev = 1'($urandom_range(0, 1));
        tx_bit  = tx_prev;
        case (adc_mode)
            0:       adc_d = 8'($urandom_range(0, 255));
            1:       adc_d = sq_cnt[3] ? amp : 8'd0;
            default: adc_d = 8'd128;
        endcase
        sq_cnt++;
        @(negedge osc_clk);
        #1;
        chk1("coil_a", a_mod, rst ? 1'b0 : tx_prev);
        chk1("coil_b", b_mod, rst ? 1'b0 : tx_prev);
    endtask

    // Tick k of a RUN period (k = tick_cnt value seen by this edge, counted from entry).
    task automatic run_tick(input int k);
        int c;
        step();
        c = k % 128;
        chk1("sspclk_a", a_clk, (k % 16) < 8);
        chk1("sspfrm_a", a_frm, c >= 7 && c <= 22);
        chk1("fvalid_a", a_fv, c == 115);
        chk1("sspclk_b", b_clk, (k % 32) < 16);
        chk1("sspfrm_b", b_frm, c >= 15 && c <= 46);
        chk1("fvalid_b", b_fv, c == 99);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        tx_bit    = 1'b0;
        adc_d     = 8'd0;
        threshold = 10'd40;
        rp_a      = 4'd3;
        rp_b      = 5'd3;

        // Reset dominates enable; everything stays 0.
        repeat (3) begin
            step();
            chk8("rst_ctl_a", {3'b0, a_cb, a_fv, a_clk, a_frm, a_din}, 8'h00);
            chk8("rst_fw_a", a_fw, 8'h00);
            chk8("rst_ctl_b", {3'b0, b_cb, b_fv, b_clk, b_frm, b_din}, 8'h00);
            chk8("rst_fw_b", {4'h0, b_fw}, 8'h00);
        end

        // Release: this edge is IDLE -> RUN, counter still 0.
        rst      = 1'b0;
        adc_mode = 1;
        amp      = 8'd200;
        sq_cnt   = 0;
        step();
        chk1("entry_clk_a", a_clk, 1'b0);

        // Strong square wave; continue into frame 3 up to tick 85 (bit_idx 5).
        for (int k = 0; k < 342; k++) begin
            run_tick(k);
            if (k == 3)   chk1("cb_first_a", a_cb, 1'b0);
            if (k == 18)  chk1("cb_pre_a", a_cb, 1'b0);
            if (k == 19)  chk1("cb_second_a", a_cb, 1'b1);
            if (k == 31)  chk1("din_pre_a", a_din, 1'b0);
            if (k == 32)  chk1("din_lat_a", a_din, 1'b1);
            if (k == 115) chk8("fw1_a", a_fw, 8'h7F);
            if (k == 243) chk8("fw2_a", a_fw, 8'hFF);
            if (k == 34)  chk1("cb_pre_b", b_cb, 1'b0);
            if (k == 35)  chk1("cb_second_b", b_cb, 1'b1);
            if (k == 63)  chk1("din_pre_b", b_din, 1'b0);
            if (k == 64)  chk1("din_lat_b", b_din, 1'b1);
            if (k == 99)  chk8("fw1_b", {4'h0, b_fw}, 8'h07);
            if (k == 227) chk8("fw2_b", {4'h0, b_fw}, 8'h0F);
        end

        // Drop enable mid-frame: SSP forced low on the same edge, frame discarded.
        enable = 1'b0;
        step();
        chk1("exit_clk_a", a_clk, 1'b0);
        chk1("exit_din_a", a_din, 1'b0);
        chk1("exit_fv_a", a_fv, 1'b0);
        chk1("exit_din_b", b_din, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step();
            chk1("idle_fv_a", a_fv, 1'b0);
            chk1("idle_clk_a", a_clk, 1'b0);
            chk1("idle_fv_b", b_fv, 1'b0);
        end
        chk8("idle_fw_a", a_fw, 8'hFF);

        // Re-enable: counter restarts at 0, first decision is 0 again.
        enable = 1'b1;
        step();
        chk1("reentry_clk_a", a_clk, 1'b0);
        for (int k = 0; k < 128; k++) begin
            run_tick(k);
            if (k == 3)   chk1("re_cb_first_a", a_cb, 1'b0);
            if (k == 19)  chk1("re_cb_second_a", a_cb, 1'b1);
            if (k == 115) chk8("re_fw_a", a_fw, 8'h7F);
            if (k == 35)  chk1("re_cb_second_b", b_cb, 1'b1);
            if (k == 99)  chk8("re_fw_b", {4'h0, b_fw}, 8'h07);
        end

        // Constant input: y = 0, nothing detected.
        enable   = 1'b0;
        adc_mode = 2;
        repeat (8) step();
        enable = 1'b1;
        step();
        for (int k = 0; k < 128; k++) begin
            run_tick(k);
            chk1("flat_din_a", a_din, 1'b0);
            chk1("flat_din_b", b_din, 1'b0);
            if (k % 16 == 3) chk1("flat_cb_a", a_cb, 1'b0);
            if (k == 115) chk8("flat_fw_a", a_fw, 8'h00);
            if (k == 99)  chk8("flat_fw_b", {4'h0, b_fw}, 8'h00);
        end

        // Weak square wave (peak |y| = 30): below 40, above 20 after a live change.
        enable   = 1'b0;
        adc_mode = 1;
        amp      = 8'd10;
        repeat (8) step();
        enable = 1'b1;
        step();
        for (int k = 0; k < 96; k++) begin
            if (k == 64) threshold = 10'd20;
            run_tick(k);
            if (k % 16 == 3 || k == 66) chk1("weak_cb_a", a_cb, k >= 67);
        end
        threshold = 10'd40;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
